// File: rtl/ann_pkg.sv
// Shared classifier constants and the backward-pass sequencer state encoding.
package ann_pkg;

    localparam int CLASSIFICATIONS = 10;
    localparam int NORMALIZED_SIZE = 15;
    localparam int ERR_SIZE        = NORMALIZED_SIZE + 1;

    // Full-scale target used for the labelled class.
    localparam logic [NORMALIZED_SIZE-1:0] FULL_SCALE = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/output_error_calc_err_elem.sv
// Single-class error element: (target - norm) at ERR bits, forced to zero when
// the ReLU output is zero.
module err_elem
    import ann_pkg::*;
#(
    parameter int N   = NORMALIZED_SIZE,
    parameter int ERR = ERR_SIZE
) (
    input  logic [N-1:0]   i_norm,
    input  logic           i_label,
    output logic [ERR-1:0] o_err
);

    logic [ERR-1:0] w_target;
    logic [ERR-1:0] w_norm_ext;

    always_comb begin
        w_target   = i_label ? ERR'({N{1'b1}}) : '0;
        w_norm_ext = ERR'(i_norm);
        o_err      = (i_norm == '0) ? '0 : (w_target - w_norm_ext);
    end

endmodule

// File: rtl/output_error_calc.sv
// Output-layer error sequencer: one class per cycle through a shared err_elem.
// Optional feature macro ERR_ABS_SUM_EN adds err_abs_sum (sum of |error_i|).
module output_error_calc
    import ann_pkg::*;
#(
    parameter int C   = CLASSIFICATIONS,
    parameter int N   = NORMALIZED_SIZE,
    parameter int ERR = ERR_SIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [C*N-1:0]   normalized_results,
    input  logic [C-1:0]     class_hotcoded,
    input  logic [C-1:0]     label,
    output logic [C*ERR-1:0] error_vec,
    output logic             correct,
    output logic             label_err,
    output logic             busy,
`ifdef ERR_ABS_SUM_EN
    output logic [N+$clog2(C)-1:0] err_abs_sum,
`endif
    output logic             done
);

    localparam int             IW   = $clog2(C);
    localparam logic [IW-1:0]  LAST = IW'(C - 1);

    state_t           r_state;
    state_t           w_next;
    logic [C*N-1:0]   r_norm;
    logic [C-1:0]     r_label;
    logic [IW-1:0]    r_idx;
    logic [C*ERR-1:0] r_err_vec;
    logic             r_correct;
    logic             r_label_err;
    logic             r_done;
    logic             w_accept;
    logic             w_lab_ok;
    logic [N-1:0]     w_norm_sel;
    logic             w_label_sel;
    logic [ERR-1:0]   w_err;

    assign w_accept    = (r_state == IDLE) && start;
    assign w_lab_ok    = $onehot(label);
    assign w_norm_sel  = r_norm[r_idx*N +: N];
    assign w_label_sel = r_label[r_idx];

    err_elem #(.N(N), .ERR(ERR)) u_err_elem (
        .i_norm  (w_norm_sel),
        .i_label (w_label_sel),
        .o_err   (w_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A bad label skips CALC so error_vec stays at its cleared value.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_lab_ok ? CALC : DONE;
            CALC:    if (r_idx == LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_norm      <= '0;
            r_label     <= '0;
            r_idx       <= '0;
            r_err_vec   <= '0;
            r_correct   <= 1'b0;
            r_label_err <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (w_accept) begin
                r_norm      <= normalized_results;
                r_label     <= label;
                r_idx       <= '0;
                r_err_vec   <= '0;
                r_correct   <= w_lab_ok && (class_hotcoded == label);
                r_label_err <= !w_lab_ok;
            end else if (r_state == CALC) begin
                r_err_vec[r_idx*ERR +: ERR] <= w_err;
                if (r_idx != LAST) r_idx <= r_idx + IW'(1);
            end
        end
    end

`ifdef ERR_ABS_SUM_EN
    localparam int SW = N + $clog2(C);

    logic [SW-1:0]  r_abs_sum;
    logic [ERR-1:0] w_err_abs;

    assign w_err_abs = w_err[ERR-1] ? -w_err : w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    r_abs_sum <= '0;
        else if (w_accept)          r_abs_sum <= '0;
        else if (r_state == CALC)   r_abs_sum <= r_abs_sum + SW'(w_err_abs);
    end

    assign err_abs_sum = r_abs_sum;
`endif

    assign error_vec = r_err_vec;
    assign correct   = r_correct;
    assign label_err = r_label_err;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_output_error_calc.sv
// Scoreboard bench for output_error_calc (C=10, N=15); expected results are
// queued at start and compared when done pulses.
module tb_output_error_calc;

    localparam int C   = 10;
    localparam int N   = 15;
    localparam int ERR = 16;
    localparam int SW  = N + 4;
    localparam logic [ERR-1:0] TGT = 16'h7FFF;

    typedef struct packed {
        logic [C*ERR-1:0] ev;
        logic             cor;
        logic             le;
        logic [7:0]       lat;
        logic [SW-1:0]    abs;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [C*N-1:0]   normalized_results = '0;
    logic [C-1:0]     class_hotcoded = '0;
    logic [C-1:0]     label = '0;
    logic [C*ERR-1:0] error_vec;
    logic             correct;
    logic             label_err;
    logic             busy;
    logic             done;
`ifdef ERR_ABS_SUM_EN
    logic [SW-1:0]    err_abs_sum;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    output_error_calc dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .normalized_results (normalized_results),
        .class_hotcoded     (class_hotcoded),
        .label              (label),
        .error_vec          (error_vec),
        .correct            (correct),
        .label_err          (label_err),
        .busy               (busy),
`ifdef ERR_ABS_SUM_EN
        .err_abs_sum        (err_abs_sum),
`endif
        .done               (done)
    );

    task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [C*N-1:0] nr, input logic [C-1:0] pr,
                                   input logic [C-1:0] lb);
        exp_t e;
        logic [N-1:0] n;
        e.ev  = '0;
        e.abs = '0;
        e.le  = !$onehot(lb);
        e.cor = !e.le && (pr == lb);
        e.lat = e.le ? 8'd1 : 8'(C + 1);
        if (!e.le) begin
            for (int i = 0; i < C; i++) begin
                n = nr[i*N +: N];
                if (n != '0) begin
                    e.ev[i*ERR +: ERR] = (lb[i] ? TGT : 16'h0000) - {1'b0, n};
                    e.abs = e.abs + (lb[i] ? SW'(TGT - {1'b0, n}) : SW'(n));
                end
            end
        end
        return e;
    endfunction

    function automatic logic [C*N-1:0] fill(input logic [N-1:0] v);
        logic [C*N-1:0] r;
        for (int i = 0; i < C; i++) r[i*N +: N] = v;
        return r;
    endfunction

    task automatic run_vec(input logic [C*N-1:0] nr, input logic [C-1:0] pr,
                           input logic [C-1:0] lb, input bit mid_start);
        exp_t e;
        int   n;
        @(negedge clk);
        normalized_results = nr;
        class_hotcoded     = pr;
        label              = lb;
        start              = 1'b1;
        sb.push_back(model(nr, pr, lb));
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 40) begin
            if (mid_start && n == 4) begin
                start              = 1'b1;
                normalized_results = ~nr;
                label              = 10'h001;
                class_hotcoded     = 10'h001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!done) begin
            check_val("done_timeout", 0, 1);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check_val("latency",   n,         e.lat);
            check_val("error_vec", error_vec, e.ev);
            check_val("correct",   correct,   e.cor);
            check_val("label_err", label_err, e.le);
`ifdef ERR_ABS_SUM_EN
            check_val("err_abs_sum", err_abs_sum, e.abs);
`endif
            @(negedge clk);
            check_val("done_pulse", done, 0);
            check_val("busy_idle",  busy, 0);
            check_val("hold_vec",   error_vec, e.ev);
        end
    endtask

    logic [C*N-1:0] v1, v2, vr;
    logic [C-1:0]   lr, pr;
    int             n;

    initial begin
        v1 = fill(15'h0100);
        v1[3*N +: N] = 15'h6000;

        #12;
        check_val("rst_error_vec", error_vec, 0);
        check_val("rst_correct",   correct,   0);
        check_val("rst_label_err", label_err, 0);
        check_val("rst_busy",      busy,      0);
        check_val("rst_done",      done,      0);
        @(negedge clk);
        rst = 1'b0;

        run_vec(v1, 10'h008, 10'h008, 1'b0);

        v2 = fill(15'h1234);
        v2[5*N +: N] = '0;
        run_vec(v2, 10'h020, 10'h020, 1'b0);

        run_vec('0, 10'h002, 10'h002, 1'b0);

        run_vec(v1, 10'h008, 10'h000, 1'b0);
        run_vec(v1, 10'h011, 10'h011, 1'b0);

        v2 = fill(15'h7FFF);
        v2[0*N +: N] = 15'h0001;
        run_vec(v2, 10'h004, 10'h080, 1'b1);

        // abort mid-CALC, then a fresh run must complete normally
        @(negedge clk);
        normalized_results = v1;
        class_hotcoded     = 10'h008;
        label              = 10'h008;
        start              = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 4; n++) @(negedge clk);
        check_val("busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check_val("abort_error_vec", error_vec, 0);
        check_val("abort_busy",      busy,      0);
        check_val("abort_done",      done,      0);
        check_val("abort_correct",   correct,   0);
        check_val("abort_label_err", label_err, 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(v1, 10'h008, 10'h008, 1'b0);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < C; i++) begin
                case ($urandom_range(0, 5))
                    0:       vr[i*N +: N] = '0;
                    1:       vr[i*N +: N] = 15'h7FFF;
                    default: vr[i*N +: N] = N'($urandom_range(1, 32767));
                endcase
            end
            lr = C'(1) << $urandom_range(0, C - 1);
            pr = (t % 2 == 0) ? lr : (C'(1) << $urandom_range(0, C - 1));
            run_vec(vr, pr, lr, 1'b0);
        end

        check_val("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
